// File: rtl/xgmii_gen_pkg.sv
// Shared constants and state type for the XGMII test-frame generator.
package xgmii_gen_pkg;

   localparam logic [63:0] XGMII_IDLE       = 64'h0707070707070707;
   localparam logic [63:0] XGMII_START_WORD = 64'hD5555555555555FB;
   localparam logic [63:0] XGMII_TERM_L0    = 64'h07070707070707FD;
   localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
   localparam logic [31:0] CRC32_RESIDUE    = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      TERM,
      IFG
   } state_t;

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/eth_crc32_step.sv
// Combinational Ethernet CRC-32 update over the low nbytes lanes of a word.
module eth_crc32_step
   import xgmii_gen_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [63:0] data,
   input  logic [3:0]  nbytes,
   output logic [31:0] crc_out
);

   localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

   logic [31:0] acc;

   // Lane 0 goes first, each byte LSB first (reflected shift-right form).
   always_comb begin
      acc = crc_in;
      for (int b = 0; b < 8; b++) begin
         if (b < int'(nbytes)) begin
            acc = acc ^ {24'd0, data[8*b +: 8]};
            for (int k = 0; k < 8; k++)
               acc = acc[0] ? ((acc >> 1) ^ POLY_R) : (acc >> 1);
         end
      end
      crc_out = acc;
   end

endmodule

// File: rtl/xgmii_frame_gen.sv
// 64-bit XGMII transmit test-frame generator: fixed-length frames with
// sequence number, incrementing payload and FCS, separated by idle gaps.
module xgmii_frame_gen
   import xgmii_gen_pkg::*;
#(
   parameter int          FRAME_LEN = 64,
   parameter int          IFG_WORDS = 1,
   parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
   parameter logic [47:0] SRC_MAC   = 48'h02000000000A,
   parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] frame_limit,
   output logic [63:0] xgmii_txd,
   output logic [7:0]  xgmii_txc,
   output logic        busy,
   output logic        done,
   output logic [31:0] frame_count
);

   localparam int NW = FRAME_LEN / 8;
   localparam int WW = $clog2(NW) + 1;
   localparam logic [WW-1:0] LASTW = WW'(NW - 1);
   localparam logic [15:0] LASTG = 16'(IFG_WORDS - 1);

   state_t        state_q, state_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [15:0]   gcnt_q, gcnt_d;
   logic [31:0]   crc_q, crc_d;
   logic [31:0]   seq_q, seq_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [31:0]   sent_q, sent_d;
   logic [31:0]   lim_q, lim_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic [63:0]   txd_q, txd_d;
   logic [7:0]    txc_q, txc_d;

   logic [63:0]   dword;
   logic          last;
   logic [3:0]    nbytes;
   logic [31:0]   crc_nx;

   function automatic logic [7:0] byte_at(input int idx,
                                          input logic [31:0] s);
      logic [143:0] hdr;
      hdr = {DST_MAC, SRC_MAC, ETHERTYPE, s};
      if (idx < 18) return hdr[143-8*idx -: 8];
      return 8'((idx - 18) % 256);
   endfunction

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      gcnt_d  = gcnt_q;
      seq_d   = seq_q;
      cnt_d   = cnt_q;
      sent_d  = sent_q;
      lim_d   = lim_q;
      done_d  = done_q;
      unique case (state_q)
         IDLE: begin
            if (!enable) begin
               sent_d = '0;
               done_d = 1'b0;
            end else if (!done_q) begin
               state_d = START;
               lim_d   = frame_limit;
            end
         end
         START: begin
            state_d = DATA;
            wcnt_d  = '0;
         end
         DATA: begin
            if (wcnt_q == LASTW) begin
               state_d = TERM;
               seq_d   = seq_q + 32'd1;
               cnt_d   = cnt_q + 32'd1;
               sent_d  = sent_q + 32'd1;
               if (lim_q != '0 && sent_d == lim_q) done_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         TERM: begin
            state_d = IFG;
            gcnt_d  = '0;
         end
         IFG: begin
            if (gcnt_q == LASTG)
               state_d = (enable && !done_q) ? START : IDLE;
            else
               gcnt_d = gcnt_q + 16'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output word is built for the state being entered, so it registers
   // in the same edge as the state change.
   always_comb begin
      dword = '0;
      for (int l = 0; l < 8; l++)
         dword[8*l +: 8] = byte_at(int'(wcnt_d) * 8 + l, seq_q);
   end

   assign last   = (state_d == DATA) && (wcnt_d == LASTW);
   assign nbytes = last ? 4'd4 : 4'd8;

   eth_crc32_step u_crc (
      .crc_in  (crc_q),
      .data    (dword),
      .nbytes  (nbytes),
      .crc_out (crc_nx)
   );

   always_comb begin
      txd_d  = XGMII_IDLE;
      txc_d  = 8'hFF;
      crc_d  = crc_q;
      busy_d = (state_d != IDLE);
      unique case (state_d)
         START: begin
            txd_d = XGMII_START_WORD;
            txc_d = 8'h01;
            crc_d = '1;
         end
         DATA: begin
            txc_d = 8'h00;
            if (last) begin
               txd_d = {~crc_nx, dword[31:0]};
            end else begin
               txd_d = dword;
               crc_d = crc_nx;
            end
         end
         TERM: txd_d = XGMII_TERM_L0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         gcnt_q  <= '0;
         crc_q   <= '1;
         seq_q   <= '0;
         cnt_q   <= '0;
         sent_q  <= '0;
         lim_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         txd_q   <= XGMII_IDLE;
         txc_q   <= 8'hFF;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         gcnt_q  <= gcnt_d;
         crc_q   <= crc_d;
         seq_q   <= seq_d;
         cnt_q   <= cnt_d;
         sent_q  <= sent_d;
         lim_q   <= lim_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         txd_q   <= txd_d;
         txc_q   <= txc_d;
      end
   end

   assign xgmii_txd   = txd_q;
   assign xgmii_txc   = txc_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign frame_count = cnt_q;

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Directed and randomized bench for xgmii_frame_gen, with a byte-queue
// frame model and a bitwise CRC reference.
module tb_xgmii_frame_gen;

   localparam int SLEN = 64;
   localparam int SIFG = 2;
   localparam int LLEN = 1520;
   localparam int LIFG = 1;
   localparam logic [47:0] DST = 48'hFFFFFFFFFFFF;
   localparam logic [47:0] SRC = 48'h02000000000A;
   localparam logic [15:0] ETY = 16'h88B5;
   localparam logic [71:0] IDLE72  = {8'hFF, 64'h0707070707070707};
   localparam logic [71:0] START72 = {8'h01, 64'hD5555555555555FB};
   localparam logic [71:0] TERM72  = {8'hFF, 64'h07070707070707FD};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, s_en, l_rst, l_en;
   logic [31:0] s_lim, l_lim;
   logic [63:0] s_txd, l_txd;
   logic [7:0]  s_txc, l_txc;
   logic        s_busy, l_busy, s_done, l_done;
   logic [31:0] s_cnt, l_cnt;

   xgmii_frame_gen #(.FRAME_LEN(SLEN), .IFG_WORDS(SIFG)) dut (
      .clk(clk), .rst(rst), .enable(s_en), .frame_limit(s_lim),
      .xgmii_txd(s_txd), .xgmii_txc(s_txc), .busy(s_busy),
      .done(s_done), .frame_count(s_cnt)
   );

   xgmii_frame_gen #(.FRAME_LEN(LLEN), .IFG_WORDS(LIFG)) dut_l (
      .clk(clk), .rst(l_rst), .enable(l_en), .frame_limit(l_lim),
      .xgmii_txd(l_txd), .xgmii_txc(l_txc), .busy(l_busy),
      .done(l_done), .frame_count(l_cnt)
   );

   logic        sel;
   logic [63:0] mtxd;
   logic [7:0]  mtxc;
   logic        mbusy, mdone;
   logic [31:0] mcnt;

   always_comb begin
      mtxd  = sel ? l_txd  : s_txd;
      mtxc  = sel ? l_txc  : s_txc;
      mbusy = sel ? l_busy : s_busy;
      mdone = sel ? l_done : s_done;
      mcnt  = sel ? l_cnt  : s_cnt;
   end

   int n_pass = 0;
   int n_tot  = 0;
   logic [7:0]  expq[$];
   logic [31:0] exp_fcs;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [71:0] obs,
                      input logic [71:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_idle(input string tag, input logic b);
      chk(tag, {mtxc, mtxd}, IDLE72);
      chk({tag, "_busy"}, 72'(mbusy), 72'(b));
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                            input logic [7:0] b);
      c = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   task automatic build(input int len, input logic [31:0] seq);
      logic [31:0] c;
      expq.delete();
      for (int i = 5; i >= 0; i--) expq.push_back(DST[8*i +: 8]);
      for (int i = 5; i >= 0; i--) expq.push_back(SRC[8*i +: 8]);
      for (int i = 1; i >= 0; i--) expq.push_back(ETY[8*i +: 8]);
      for (int i = 3; i >= 0; i--) expq.push_back(seq[8*i +: 8]);
      for (int k = 0; expq.size() < len - 4; k++)
         expq.push_back(8'(k % 256));
      c = 32'hFFFFFFFF;
      foreach (expq[i]) c = crc_byte(c, expq[i]);
      exp_fcs = ~c;
   endtask

   task automatic frame_body(input int len, input logic [31:0] seq,
                             input int drop_at);
      logic [31:0] c;
      logic [63:0] e;
      int idx;
      build(len, seq);
      chk("start", {mtxc, mtxd}, START72);
      chk("start_busy", 72'(mbusy), 72'd1);
      c = 32'hFFFFFFFF;
      for (int w = 0; w < len / 8; w++) begin
         tick();
         for (int l = 0; l < 8; l++) begin
            idx = 8 * w + l;
            if (idx < len - 4) e[8*l +: 8] = expq[idx];
            else e[8*l +: 8] = exp_fcs[8*(idx-(len-4)) +: 8];
            c = crc_byte(c, mtxd[8*l +: 8]);
         end
         chk($sformatf("data_w%0d", w), {mtxc, mtxd}, {8'h00, e});
         if (w == drop_at) s_en = 1'b0;
      end
      chk("fcs_residue", 72'(c), 72'(32'hDEBB20E3));
      tick();
      chk("term", {mtxc, mtxd}, TERM72);
   endtask

   task automatic gap(input int n);
      for (int g = 0; g < n; g++) begin
         tick();
         chk_idle("ifg", 1'b1);
      end
   endtask

   initial begin
      int drop;
      sel = 1'b0;
      rst = 1'b1; s_en = 1'b1; s_lim = 32'd1;
      l_rst = 1'b1; l_en = 1'b0; l_lim = 32'd0;
      repeat (4) begin
         tick();
         chk_idle("reset", 1'b0);
      end
      chk("reset_count", 72'(mcnt), 72'd0);
      chk("reset_done", 72'(mdone), 72'd0);

      // single frame, limit 1
      rst = 1'b0; l_rst = 1'b0; s_en = 1'b0;
      repeat ($urandom_range(1, 3)) begin
         tick();
         chk_idle("pre", 1'b0);
      end
      s_en = 1'b1; s_lim = 32'd1;
      tick();
      frame_body(SLEN, 32'd0, -1);
      chk("single_count", 72'(mcnt), 72'd1);
      chk("single_done", 72'(mdone), 72'd1);
      gap(SIFG);
      repeat (4) begin
         tick();
         chk_idle("no_restart", 1'b0);
      end

      // back-to-back, limit 3
      rst = 1'b1; s_lim = 32'd3;
      tick();
      chk_idle("rst2", 1'b0);
      rst = 1'b0;
      tick();
      for (int f = 0; f < 3; f++) begin
         frame_body(SLEN, 32'(f), -1);
         chk("b2b_count", 72'(mcnt), 72'(f + 1));
         chk("b2b_done", 72'(mdone), 72'(f == 2));
         gap(SIFG);
         tick();
      end
      chk_idle("b2b_end", 1'b0);

      // enable drop mid-frame, unlimited
      s_en = 1'b0;
      tick();
      chk("done_clear", 72'(mdone), 72'd0);
      s_lim = 32'd0; s_en = 1'b1;
      drop = $urandom_range(1, 6);
      tick();
      frame_body(SLEN, 32'd3, drop);
      chk("drop_count", 72'(mcnt), 72'd4);
      gap(SIFG);
      repeat (3) begin
         tick();
         chk_idle("drop_idle", 1'b0);
      end

      // reset mid-frame
      s_en = 1'b1;
      build(SLEN, 32'd4);
      tick();
      chk("rm_start", {mtxc, mtxd}, START72);
      for (int w = 0; w < 5; w++) begin
         tick();
         chk("rm_data", {mtxc, mtxd[31:0]},
             {8'h00, 32'h0, expq[8*w+3], expq[8*w+2],
              expq[8*w+1], expq[8*w]});
      end
      rst = 1'b1;
      tick();
      chk_idle("rm_idle", 1'b0);
      chk("rm_count", 72'(mcnt), 72'd0);
      rst = 1'b0; s_lim = 32'd1;
      tick();
      frame_body(SLEN, 32'd0, -1);
      chk("rm_seq0_count", 72'(mcnt), 72'd1);
      s_en = 1'b0;

      // long frame on the second instance
      sel = 1'b1; l_en = 1'b1; l_lim = 32'd1;
      tick();
      frame_body(LLEN, 32'd0, -1);
      chk("long_count", 72'(mcnt), 72'd1);
      chk("long_done", 72'(mdone), 72'd1);
      gap(LIFG);
      tick();
      chk_idle("long_end", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
